// File: rtl/riscv_dual_port_mem.sv
// Dual-port (instruction read + data read/write) word memory with a shared array,
// fixed read latency, request/ready handshake, error flags and a post-reset clear.

module riscv_dual_port_mem_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_err
);
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      logic         v_reg;
      logic         e_reg;
      logic [W-1:0] d_reg;
      logic         v_next;
      logic         e_next;
      logic [W-1:0] d_next;

      if (gi == 0) begin : g_head
        assign v_next = in_valid;
        assign e_next = in_err;
        assign d_next = in_data;
      end else begin : g_tail
        assign v_next = g_stage[gi-1].v_reg;
        assign e_next = g_stage[gi-1].e_reg;
        assign d_next = g_stage[gi-1].d_reg;
      end

      // Data/err only advance with a valid, so the last stage holds between pulses.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_reg <= 1'b0;
          e_reg <= 1'b0;
          d_reg <= '0;
        end else begin
          v_reg <= v_next;
          if (v_next) begin
            e_reg <= e_next;
            d_reg <= d_next;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[LAT-1].v_reg;
  assign out_err   = g_stage[LAT-1].e_reg;
  assign out_data  = g_stage[LAT-1].d_reg;
endmodule

module riscv_dual_port_mem #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ready,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  init_done
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);
  localparam longint unsigned   LIMIT      = longint'(DEPTH) * longint'(BE_W);
  localparam logic [IDX_W-1:0]  LAST       = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   cnt_reg;
  logic               run_reg;
  logic [DATA_W-1:0]  mem [DEPTH];

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return ((a & ALIGN_MASK) != '0) || (64'(a) >= LIMIT);
  endfunction

  logic               i_bad, d_bad, i_acc, d_acc, d_wr, clear_we;
  logic [IDX_W-1:0]   i_idx, d_idx;
  logic [DATA_W-1:0]  i_cap, d_cap, wmask;

  assign i_bad = addr_bad(i_addr);
  assign d_bad = addr_bad(d_addr);
  assign i_idx = i_addr[OFF +: IDX_W];
  assign d_idx = d_addr[OFF +: IDX_W];
  assign i_acc = i_req && run_reg;
  assign d_acc = d_req && run_reg;
  assign d_wr  = d_acc && d_we && !d_bad;

  // Reads sample the array before this edge's write lands, so a same-edge I read sees old data.
  assign i_cap = i_bad ? '0 : mem[i_idx];
  assign d_cap = (d_bad || d_we) ? '0 : mem[d_idx];

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{d_be[gi]}};
    end
  endgenerate

  // Gated by rst so holding reset never touches the array.
  assign clear_we = rst && (state_reg == INIT) && (CLEAR_ON_RST != 0);

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[cnt_reg] <= '0;
    end else if (d_wr) begin
      mem[d_idx] <= (mem[d_idx] & ~wmask) | (d_wdata & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
      run_reg   <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          if (CLEAR_ON_RST == 0 || cnt_reg == LAST) begin
            state_reg <= RUN;
            run_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RUN:     run_reg <= 1'b1;
        default: state_reg <= INIT;
      endcase
    end
  end

  assign i_ready   = run_reg;
  assign d_ready   = run_reg;
  assign init_done = run_reg;

  riscv_dual_port_mem_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_i_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (i_acc),
    .in_data   (i_cap),
    .in_err    (i_bad),
    .out_valid (i_rvalid),
    .out_data  (i_rdata),
    .out_err   (i_err)
  );

  riscv_dual_port_mem_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_d_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_acc),
    .in_data   (d_cap),
    .in_err    (d_bad),
    .out_valid (d_rvalid),
    .out_data  (d_rdata),
    .out_err   (d_err)
  );
endmodule

// File: tb/tb_riscv_dual_port_mem.sv
// Bench for riscv_dual_port_mem: instance A (RD_LAT=3, clear on reset) checked through a
// response scoreboard, instance B (RD_LAT=2, no clear) checked cycle by cycle.
`timescale 1ns/1ps
module tb_riscv_dual_port_mem;
  localparam int DEP   = 16;
  localparam int LAT_A = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        a_rst, a_i_req, a_i_ready, a_i_rvalid, a_i_err;
  logic [31:0] a_i_addr, a_i_rdata;
  logic        a_d_req, a_d_we, a_d_ready, a_d_rvalid, a_d_err, a_init_done;
  logic [3:0]  a_d_be;
  logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;

  logic        b_rst, b_i_req, b_i_ready, b_i_rvalid, b_i_err;
  logic [31:0] b_i_addr, b_i_rdata;
  logic        b_d_req, b_d_we, b_d_ready, b_d_rvalid, b_d_err, b_init_done;
  logic [3:0]  b_d_be;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;

  riscv_dual_port_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEP), .RD_LAT(LAT_A), .CLEAR_ON_RST(1)) dut_a (
    .clk(clk), .rst(a_rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready), .i_rvalid(a_i_rvalid),
    .i_rdata(a_i_rdata), .i_err(a_i_err),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ready(a_d_ready), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata), .d_err(a_d_err),
    .init_done(a_init_done)
  );

  riscv_dual_port_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEP), .RD_LAT(2), .CLEAR_ON_RST(0)) dut_b (
    .clk(clk), .rst(b_rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rvalid(b_i_rvalid),
    .i_rdata(b_i_rdata), .i_err(b_i_err),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .d_err(b_d_err),
    .init_done(b_init_done)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } resp_t;

  resp_t       iq[$];
  resp_t       dq[$];
  logic [31:0] model [DEP];

  // Scoreboard for instance A: every rvalid must match the oldest expectation and its due cycle.
  always @(negedge clk) begin
    resp_t e;
    if (a_i_rvalid) begin
      tests++;
      if (iq.size() == 0) begin
        fails++;
        $display("FAIL i_resp: unexpected rvalid at cycle %0d data=%h", cyc, a_i_rdata);
      end else begin
        e = iq.pop_front();
        if (a_i_rdata !== e.data || a_i_err !== e.err || cyc !== e.due) begin
          fails++;
          $display("FAIL i_resp: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                   a_i_rdata, a_i_err, cyc, e.data, e.err, e.due);
        end else begin
          $display("[TB] i rsp cyc=%0d data=%h err=%b", cyc, a_i_rdata, a_i_err);
        end
      end
    end else if (iq.size() > 0 && cyc >= iq[0].due) begin
      tests++;
      fails++;
      $display("FAIL i_resp: no rvalid at cycle %0d, expected data=%h", cyc, iq[0].data);
      e = iq.pop_front();
    end
    if (a_d_rvalid) begin
      tests++;
      if (dq.size() == 0) begin
        fails++;
        $display("FAIL d_resp: unexpected rvalid at cycle %0d data=%h", cyc, a_d_rdata);
      end else begin
        e = dq.pop_front();
        if (a_d_rdata !== e.data || a_d_err !== e.err || cyc !== e.due) begin
          fails++;
          $display("FAIL d_resp: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                   a_d_rdata, a_d_err, cyc, e.data, e.err, e.due);
        end else begin
          $display("[TB] d rsp cyc=%0d data=%h err=%b", cyc, a_d_rdata, a_d_err);
        end
      end
    end else if (dq.size() > 0 && cyc >= dq[0].due) begin
      tests++;
      fails++;
      $display("FAIL d_resp: no rvalid at cycle %0d, expected data=%h", cyc, dq[0].data);
      e = dq.pop_front();
    end
  end

  function automatic logic tb_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEP * 4));
  endfunction

  // Called at a negedge: drives one cycle of requests on A and records what must come back.
  task automatic a_issue(input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] daddr, input logic [31:0] dwdata);
    resp_t r;
    logic  bad;
    a_i_req = ireq; a_i_addr = iaddr;
    a_d_req = dreq; a_d_we = dwe; a_d_be = dbe; a_d_addr = daddr; a_d_wdata = dwdata;
    if (ireq) begin
      bad    = tb_bad(iaddr);
      r.data = bad ? 32'h0 : model[iaddr[5:2]];
      r.err  = bad;
      r.due  = cyc + LAT_A;
      iq.push_back(r);
    end
    if (dreq) begin
      bad   = tb_bad(daddr);
      r.err = bad;
      r.due = cyc + LAT_A;
      if (dwe) begin
        r.data = 32'h0;
        if (!bad)
          for (int k = 0; k < 4; k++)
            if (dbe[k]) model[daddr[5:2]][k*8 +: 8] = dwdata[k*8 +: 8];
      end else begin
        r.data = bad ? 32'h0 : model[daddr[5:2]];
      end
      dq.push_back(r);
    end
    @(negedge clk);
  endtask

  task automatic a_idle();
    a_i_req = 1'b0;
    a_d_req = 1'b0;
    a_d_we  = 1'b0;
  endtask

  task automatic a_drain();
    for (int k = 0; k < 30 && (iq.size() > 0 || dq.size() > 0); k++) @(negedge clk);
    @(negedge clk);
    tests++;
    if (iq.size() != 0 || dq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d i and %0d d responses still pending, required 0", iq.size(), dq.size());
      iq.delete();
      dq.delete();
    end
  endtask

  task automatic a_wait_init(input string name);
    for (int k = 0; k < DEP; k++) begin
      tests++;
      if ({a_init_done, a_i_ready, a_d_ready} !== 3'b000) begin
        fails++;
        $display("FAIL %s: init/ready=%b at cycle %0d after release, required 000", name,
                 {a_init_done, a_i_ready, a_d_ready}, k);
      end
      @(negedge clk);
    end
    tests++;
    if ({a_init_done, a_i_ready, a_d_ready} !== 3'b111) begin
      fails++;
      $display("FAIL %s: init/ready=%b after %0d cycles, required 111", name,
               {a_init_done, a_i_ready, a_d_ready}, DEP);
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_idle();
    b_i_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = 4'h0;
    b_i_addr = '0; b_d_addr = '0; b_d_wdata = '0;
    #2;
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_i_ready, a_i_rvalid, a_i_rdata, a_i_err, a_d_ready, a_d_rvalid, a_d_rdata, a_d_err, a_init_done} !== '0) begin
      fails++;
      $display("FAIL reset_a: outputs=%h, required 0",
               {a_i_ready, a_i_rvalid, a_i_rdata, a_i_err, a_d_ready, a_d_rvalid, a_d_rdata, a_d_err, a_init_done});
    end
    tests++;
    if ({b_i_ready, b_i_rvalid, b_i_rdata, b_i_err, b_d_ready, b_d_rvalid, b_d_rdata, b_d_err, b_init_done} !== '0) begin
      fails++;
      $display("FAIL reset_b: outputs=%h, required 0",
               {b_i_ready, b_i_rvalid, b_i_rdata, b_i_err, b_d_ready, b_d_rvalid, b_d_rdata, b_d_err, b_init_done});
    end
    for (int w = 0; w < DEP; w++) model[w] = 32'h0;
    a_rst = 1'b1;
    a_wait_init("init_a");
    for (int w = 0; w < DEP; w++) a_issue(1'b1, 32'(w * 4), 1'b1, 1'b0, 4'h0, 32'((DEP - 1 - w) * 4), 32'h0);
    a_idle();
    a_drain();
  endtask

  task automatic test_write_read();
    a_issue(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
    a_issue(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    a_idle();
    a_drain();
    repeat (2) @(negedge clk);
    tests++;
    if (a_d_rvalid !== 1'b0 || a_d_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL hold: rvalid=%b rdata=%h, required rvalid=0 rdata=deadbeef", a_d_rvalid, a_d_rdata);
    end
  endtask

  task automatic test_byte_strobe();
    a_issue(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h11223344);
    a_issue(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h4, 32'hAABBCCDD);
    a_issue(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    a_issue(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h4, 32'hFFFFFFFF);
    a_issue(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    a_idle();
    a_drain();
  endtask

  task automatic test_errors();
    a_issue(1'b1, 32'(DEP * 4), 1'b1, 1'b0, 4'h0, 32'h6, 32'h0);
    a_issue(1'b1, 32'h3D, 1'b1, 1'b1, 4'hF, 32'h6, 32'hFFFFFFFF);
    a_issue(1'b1, 32'h3C, 1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678);
    a_issue(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    a_issue(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'hFFFFFFFC, 32'h0);
    a_idle();
    a_drain();
  endtask

  task automatic test_same_edge();
    a_issue(1'b1, 32'h10, 1'b1, 1'b1, 4'hF, 32'h10, 32'h55);
    a_issue(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    a_idle();
    a_drain();
  endtask

  task automatic test_back_to_back();
    for (int w = 8; w < 14; w++)
      a_issue(1'b1, 32'((w - 1) * 4), 1'b1, 1'b1, 4'(1 << (w % 4)) | 4'b0001, 32'(w * 4), $urandom);
    for (int w = 8; w < 14; w++)
      a_issue(1'b1, 32'(w * 4), 1'b1, 1'b0, 4'h0, 32'((21 - w) * 4), 32'h0);
    a_idle();
    a_drain();
  endtask

  task automatic test_reset_inflight();
    for (int w = 0; w < DEP; w++) a_issue(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'(w * 4), 32'hA5000000 | 32'(w + 1));
    a_idle();
    a_drain();
    a_issue(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    a_issue(1'b1, 32'hC, 1'b1, 1'b0, 4'h0, 32'hC, 32'h0);
    a_idle();
    iq.delete();
    dq.delete();
    a_rst = 1'b0;
    #1;
    tests++;
    if ({a_i_ready, a_i_rvalid, a_i_rdata, a_i_err, a_d_ready, a_d_rvalid, a_d_rdata, a_d_err, a_init_done} !== '0) begin
      fails++;
      $display("FAIL inflight_reset: outputs=%h, required 0",
               {a_i_ready, a_i_rvalid, a_i_rdata, a_i_err, a_d_ready, a_d_rvalid, a_d_rdata, a_d_err, a_init_done});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if ({a_i_rvalid, a_d_rvalid} !== 2'b00) begin
        fails++;
        $display("FAIL inflight_drop: rvalid i/d=%b in reset, required 00", {a_i_rvalid, a_d_rvalid});
      end
    end
    for (int w = 0; w < DEP; w++) model[w] = 32'h0;
    a_rst = 1'b1;
    a_wait_init("reinit_a");
    for (int w = 0; w < DEP; w++) a_issue(1'b1, 32'(w * 4), 1'b1, 1'b0, 4'h0, 32'(w * 4), 32'h0);
    a_idle();
    a_drain();
  endtask

  task automatic test_lat2_noclear();
    @(negedge clk);
    b_rst = 1'b1;
    tests++;
    if ({b_init_done, b_i_ready, b_d_ready} !== 3'b000) begin
      fails++;
      $display("FAIL init_b: init/ready=%b at release, required 000", {b_init_done, b_i_ready, b_d_ready});
    end
    @(negedge clk);
    tests++;
    if ({b_init_done, b_i_ready, b_d_ready} !== 3'b111) begin
      fails++;
      $display("FAIL init_b: init/ready=%b one cycle after release, required 111", {b_init_done, b_i_ready, b_d_ready});
    end
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_be = 4'hF; b_d_addr = 32'h20; b_d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    b_d_we = 1'b0;
    tests++;
    if (b_d_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL lat2_early: rvalid=%b one cycle after accept, required 0", b_d_rvalid);
    end
    @(negedge clk);
    b_d_req = 1'b0;
    tests++;
    if ({b_d_rvalid, b_d_err, b_d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL lat2_ack: rvalid=%b err=%b rdata=%h, required 1 0 00000000", b_d_rvalid, b_d_err, b_d_rdata);
    end
    @(negedge clk);
    tests++;
    if ({b_d_rvalid, b_d_err, b_d_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL lat2_read: rvalid=%b err=%b rdata=%h, required 1 0 cafef00d", b_d_rvalid, b_d_err, b_d_rdata);
    end
    @(negedge clk);
    $display("[TB] b write/read @20 done");
    b_i_req = 1'b1; b_i_addr = 32'h20; b_d_req = 1'b1; b_d_addr = 32'h20;
    @(negedge clk);
    b_i_req = 1'b0; b_d_req = 1'b0;
    b_rst = 1'b0;
    #1;
    tests++;
    if ({b_i_ready, b_i_rvalid, b_i_rdata, b_i_err, b_d_ready, b_d_rvalid, b_d_rdata, b_d_err, b_init_done} !== '0) begin
      fails++;
      $display("FAIL b_inflight_reset: outputs=%h, required 0",
               {b_i_ready, b_i_rvalid, b_i_rdata, b_i_err, b_d_ready, b_d_rvalid, b_d_rdata, b_d_err, b_init_done});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if ({b_i_rvalid, b_d_rvalid} !== 2'b00) begin
        fails++;
        $display("FAIL b_inflight_drop: rvalid i/d=%b, required 00", {b_i_rvalid, b_d_rvalid});
      end
    end
    b_rst = 1'b1;
    @(negedge clk);
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h20;
    @(negedge clk);
    b_d_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({b_d_rvalid, b_d_err, b_d_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL b_retain: rvalid=%b err=%b rdata=%h, required 1 0 cafef00d", b_d_rvalid, b_d_err, b_d_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_errors();
    test_same_edge();
    test_back_to_back();
    test_reset_inflight();
    test_lat2_noclear();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
